// File: rtl/ram_wb_gen.sv
// Small word-addressed memory with a RAM region and an I/O channel region.
// It has read-first single-cycle reads, write strobes per channel and a sticky flag for unmapped accesses.
module ram_wb_gen #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 8,
    parameter int IO_BASE = 8'h40,
    parameter int IO_CH   = 2
) (
    input  logic                      CLK_WB,
    input  logic                      RESET_N,
    input  logic [ADDR_W-1:0]         RAM_ADDR,
    input  logic [DATA_W-1:0]         RAM_IN,
    input  logic                      RAM_WEN,
    input  logic                      RAM_REN,
    output logic [DATA_W-1:0]         RAM_OUT,
    output logic                      RAM_RVALID,
    output logic [DEPTH*DATA_W-1:0]   RAM_FLAT,
    output logic [IO_CH*DATA_W-1:0]   IO_OUT,
    output logic [IO_CH-1:0]          IO_WSTB,
    input  logic [IO_CH*DATA_W-1:0]   IO_IN,
    output logic                      ERR,
    input  logic                      ERR_CLR
);

    // Reject memory maps where the regions overlap or fall outside the address space.
    if ((IO_BASE < DEPTH) || (DEPTH < 1) || (IO_CH < 1) ||
        ((64'(IO_BASE) + 64'(IO_CH)) > (64'd1 << ADDR_W))) begin : g_bad_map
        $error("ram_wb_gen: illegal DEPTH/IO_BASE/IO_CH/ADDR_W combination");
    end

    logic [DEPTH*DATA_W-1:0]  mem_q, mem_d;
    logic [IO_CH*DATA_W-1:0]  io_out_q, io_out_d;
    logic [IO_CH-1:0]         io_wstb_q, io_wstb_d;
    logic [DATA_W-1:0]        ram_out_q, ram_out_d;
    logic                     rvalid_q, rvalid_d;
    logic                     err_q, err_d;

    logic [63:0]              addr_ext_s;
    logic [DEPTH-1:0]         ram_hit_s;
    logic [IO_CH-1:0]         io_hit_s;
    logic                     mapped_s;
    logic [DATA_W-1:0]        rd_data_s;

    // Full-width address decode; zero-extension rules out any aliasing.
    always_comb begin
        addr_ext_s = 64'(RAM_ADDR);
        ram_hit_s  = '0;
        io_hit_s   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ram_hit_s[k] = (addr_ext_s == 64'(k));
        end
        for (int c = 0; c < IO_CH; c++) begin
            io_hit_s[c] = (addr_ext_s == 64'(IO_BASE + c));
        end
        mapped_s = (|ram_hit_s) | (|io_hit_s);
    end

    // Read source mux from current state, which makes same-address read/write read-first.
    always_comb begin
        rd_data_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ram_hit_s[k]) begin
                rd_data_s = mem_q[k*DATA_W +: DATA_W];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
        for (int c = 0; c < IO_CH; c++) begin
            if (io_hit_s[c]) begin
                rd_data_s = IO_IN[c*DATA_W +: DATA_W];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Next-state logic for storage, I/O registers, read port and error flag.
    always_comb begin
        mem_d     = mem_q;
        io_out_d  = io_out_q;
        io_wstb_d = '0;
        ram_out_d = ram_out_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;

        if (RAM_WEN) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (ram_hit_s[k]) begin
                    mem_d[k*DATA_W +: DATA_W] = RAM_IN;
                end else begin
                    mem_d[k*DATA_W +: DATA_W] = mem_d[k*DATA_W +: DATA_W];
                end
            end
            for (int c = 0; c < IO_CH; c++) begin
                if (io_hit_s[c]) begin
                    io_out_d[c*DATA_W +: DATA_W] = RAM_IN;
                    io_wstb_d[c]                 = 1'b1;
                end else begin
                    io_wstb_d[c] = 1'b0;
                end
            end
        end else begin
            io_wstb_d = '0;
        end

        if (RAM_REN) begin
            rvalid_d  = 1'b1;
            ram_out_d = rd_data_s;
        end else begin
            rvalid_d  = 1'b0;
        end

        // A fresh unmapped access outranks a clear in the same cycle.
        if ((RAM_WEN || RAM_REN) && !mapped_s) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous active-low reset taking priority over all accesses.
    always_ff @(posedge CLK_WB) begin
        if (!RESET_N) begin
            mem_q     <= '0;
            io_out_q  <= '0;
            io_wstb_q <= '0;
            ram_out_q <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            io_out_q  <= io_out_d;
            io_wstb_q <= io_wstb_d;
            ram_out_q <= ram_out_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    assign RAM_FLAT   = mem_q;
    assign IO_OUT     = io_out_q;
    assign IO_WSTB    = io_wstb_q;
    assign RAM_OUT    = ram_out_q;
    assign RAM_RVALID = rvalid_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_ram_wb_gen.sv
// Directed self-checking bench for ram_wb_gen at default parameters.
module tb_ram_wb_gen;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;
    localparam int IO_CH  = 2;

    logic                     clk;
    logic                     rst_n;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        wdata;
    logic                     wen;
    logic                     ren;
    logic [DATA_W-1:0]        rdata;
    logic                     rvalid;
    logic [DEPTH*DATA_W-1:0]  flat;
    logic [IO_CH*DATA_W-1:0]  io_out;
    logic [IO_CH-1:0]         io_wstb;
    logic [IO_CH*DATA_W-1:0]  io_in;
    logic                     err;
    logic                     err_clr;

    int n_checks = 0;
    int n_errors = 0;

    ram_wb_gen dut (
        .CLK_WB     (clk),
        .RESET_N    (rst_n),
        .RAM_ADDR   (addr),
        .RAM_IN     (wdata),
        .RAM_WEN    (wen),
        .RAM_REN    (ren),
        .RAM_OUT    (rdata),
        .RAM_RVALID (rvalid),
        .RAM_FLAT   (flat),
        .IO_OUT     (io_out),
        .IO_WSTB    (io_wstb),
        .IO_IN      (io_in),
        .ERR        (err),
        .ERR_CLR    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word(input int k);
        return flat[k*DATA_W +: DATA_W];
    endfunction

    initial begin
        rst_n = 1'b0; addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0;
        io_in = '0; err_clr = 1'b0;
        step(); step();
        for (int k = 0; k < DEPTH; k++) check_eq("reset_word", 32'(word(k)), 32'h0);
        check_eq("reset_io_out", 32'(io_out), 32'h0);
        check_eq("reset_wstb", 32'(io_wstb), 32'h0);
        check_eq("reset_rvalid", 32'(rvalid), 32'h0);
        check_eq("reset_rdata", 32'(rdata), 32'h0);
        check_eq("reset_err", 32'(err), 32'h0);
        rst_n = 1'b1;

        // Fill all RAM words.
        for (int k = 0; k < DEPTH; k++) begin
            addr = 8'(k); wdata = 16'hbeaf; wen = 1'b1;
            step();
            check_eq("fill_word", 32'(word(k)), 32'hbeaf);
            check_eq("fill_err", 32'(err), 32'h0);
            check_eq("fill_wstb", 32'(io_wstb), 32'h0);
        end

        // I/O writes on consecutive cycles.
        addr = 8'h40; wdata = 16'hcafe; wen = 1'b1;
        step();
        check_eq("io_wstb_ch0", 32'(io_wstb), 32'h1);
        check_eq("io_out_ch0", 32'(io_out[15:0]), 32'hcafe);
        addr = 8'h41; wdata = 16'h1234;
        step();
        check_eq("io_wstb_ch1", 32'(io_wstb), 32'h2);
        check_eq("io_out_ch1", 32'(io_out[31:16]), 32'h1234);
        check_eq("io_out_ch0_hold", 32'(io_out[15:0]), 32'hcafe);
        wen = 1'b0;
        step();
        check_eq("io_wstb_idle", 32'(io_wstb), 32'h0);

        // Back-to-back writes to one channel give one pulse each.
        addr = 8'h40; wdata = 16'h0a0a; wen = 1'b1;
        step();
        check_eq("b2b_wstb_1", 32'(io_wstb), 32'h1);
        wdata = 16'h0b0b;
        step();
        check_eq("b2b_wstb_2", 32'(io_wstb), 32'h1);
        check_eq("b2b_io_out", 32'(io_out[15:0]), 32'h0b0b);
        wen = 1'b0;
        step();
        check_eq("b2b_wstb_end", 32'(io_wstb), 32'h0);

        // Read-first on a simultaneous write/read.
        addr = 8'd3; wdata = 16'h0001; wen = 1'b1;
        step();
        wdata = 16'h00ff; ren = 1'b1;
        step();
        check_eq("rf_rdata", 32'(rdata), 32'h0001);
        check_eq("rf_rvalid", 32'(rvalid), 32'h1);
        check_eq("rf_word3", 32'(word(3)), 32'h00ff);
        wen = 1'b0; ren = 1'b0;
        step();
        check_eq("idle_rvalid", 32'(rvalid), 32'h0);
        check_eq("idle_rdata_hold", 32'(rdata), 32'h0001);

        addr = 8'd5; ren = 1'b1;
        step();
        check_eq("rd_word5", 32'(rdata), 32'hbeaf);
        check_eq("rd_word5_valid", 32'(rvalid), 32'h1);

        // I/O input read, sampled at the edge.
        io_in = {16'h5a5a, 16'h1111}; addr = 8'h41;
        step();
        io_in = '0;
        check_eq("io_in_rdata", 32'(rdata), 32'h5a5a);
        check_eq("io_in_rvalid", 32'(rvalid), 32'h1);
        check_eq("io_in_err", 32'(err), 32'h0);

        // Unmapped reads return zero, still valid, and set ERR.
        addr = 8'h08;
        step();
        check_eq("unm08_rdata", 32'(rdata), 32'h0);
        check_eq("unm08_rvalid", 32'(rvalid), 32'h1);
        check_eq("unm08_err", 32'(err), 32'h1);
        ren = 1'b0;
        step();
        check_eq("err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        step();
        check_eq("err_cleared", 32'(err), 32'h0);
        err_clr = 1'b0;

        // No aliasing: 8'h48 and 8'h42 are unmapped.
        addr = 8'd5; ren = 1'b1;
        step();
        addr = 8'h48;
        step();
        check_eq("unm48_rdata", 32'(rdata), 32'h0);
        check_eq("unm48_err", 32'(err), 32'h1);
        addr = 8'h42; ren = 1'b0; wen = 1'b1; wdata = 16'h7777; err_clr = 1'b1;
        step();
        check_eq("unm42_err_set_wins", 32'(err), 32'h1);
        check_eq("unm42_wstb", 32'(io_wstb), 32'h0);
        check_eq("unm42_io_out", 32'(io_out), {16'h1234, 16'h0b0b});

        // Clear, then clear plus unmapped write at 8'hff.
        wen = 1'b0;
        step();
        check_eq("err_cleared2", 32'(err), 32'h0);
        addr = 8'hff; wdata = 16'h1234; wen = 1'b1; err_clr = 1'b1;
        step();
        check_eq("ff_err", 32'(err), 32'h1);
        check_eq("ff_wstb", 32'(io_wstb), 32'h0);
        check_eq("ff_io_out", 32'(io_out), {16'h1234, 16'h0b0b});
        check_eq("ff_word0", 32'(word(0)), 32'hbeaf);
        check_eq("ff_word7", 32'(word(7)), 32'hbeaf);
        wen = 1'b0; err_clr = 1'b0;

        // Reset priority over write and read in the same cycle.
        addr = 8'd2; ren = 1'b1;
        step();
        check_eq("pre_rst_rvalid", 32'(rvalid), 32'h1);
        rst_n = 1'b0; wen = 1'b1; wdata = 16'h4321;
        step();
        check_eq("rst_word2", 32'(word(2)), 32'h0);
        check_eq("rst_wstb", 32'(io_wstb), 32'h0);
        check_eq("rst_rvalid", 32'(rvalid), 32'h0);
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        addr = 8'h40; ren = 1'b0;
        step();
        check_eq("rst_io_wstb", 32'(io_wstb), 32'h0);
        check_eq("rst_io_out", 32'(io_out), 32'h0);
        rst_n = 1'b1; wen = 1'b0;
        step();
        check_eq("post_rst_rvalid", 32'(rvalid), 32'h0);
        check_eq("post_rst_word2", 32'(word(2)), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
